mod_updown_counter: RTL and testbench

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

---
 rtl/mod_counter_pkg.sv | 20 ++
 rtl/mod_counter_next.sv | 73 +++++++
 rtl/mod_updown_counter.sv | 58 +++++
 tb/tb_mod_updown_counter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared constants for the modulo up/down counter.
// Holds defaults, direction encoding and the WIDTH/MODULUS legality rule.
package mod_counter_pkg;

   localparam int DEF_WIDTH   = 4;
   localparam int DEF_MODULUS = 10;

   localparam int WIDTH_MIN   = 2;
   localparam int WIDTH_MAX   = 16;
   localparam int MODULUS_MIN = 2;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   function automatic bit cfg_ok(input int w, input int m);
      return (w >= WIDTH_MIN) && (w <= WIDTH_MAX) &&
             (m >= MODULUS_MIN) && (m <= (1 << w));
   endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-value logic for mod_updown_counter.
// MOD_COUNTER_SATURATE_EN selects hold-at-end instead of wrap.
module mod_counter_next
   import mod_counter_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int MODULUS = DEF_MODULUS
) (
   input  logic [WIDTH-1:0] count,
   input  logic             up,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] next,
   output logic             wrap,
   output logic             clamp,
   output logic             tc
);

   localparam logic [WIDTH:0] TOP = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

   logic [WIDTH:0] cx;
   logic [WIDTH:0] lx;
   logic [WIDTH:0] inc;
   logic [WIDTH:0] dec;
   logic           do_load;
   logic           do_step;

   assign cx  = {1'b0, count};
   assign lx  = {1'b0, load_val};
   assign inc = cx + ONE;
   assign dec = cx - ONE;

   // End of range: increment passes the top, or decrement borrows.
   assign tc = (up == DIR_DOWN) ? dec[WIDTH] : (inc > TOP);

   assign do_load = !clr && load;
   assign do_step = !clr && !load && en;

   always_comb begin
      next  = count;
      wrap  = 1'b0;
      clamp = 1'b0;
      unique case (1'b1)
         clr: next = '0;
         do_load: begin
            if (lx > TOP) begin
               next  = TOP[WIDTH-1:0];
               clamp = 1'b1;
            end else begin
               next = load_val;
            end
         end
         do_step: begin
            if (tc) begin
               wrap = 1'b1;
`ifdef MOD_COUNTER_SATURATE_EN
               next = count;
`else
               next = (up == DIR_UP) ? '0 : TOP[WIDTH-1:0];
`endif
            end else begin
               next = (up == DIR_UP) ? inc[WIDTH-1:0]
                                     : dec[WIDTH-1:0];
            end
         end
         default: next = count;
      endcase
   end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with clear, clamped load, carry pulse.
// Define MOD_COUNTER_SATURATE_EN to saturate instead of wrapping.
module mod_updown_counter
   import mod_counter_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int MODULUS = DEF_MODULUS
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             carry,
   output logic             load_err
);

   if (!cfg_ok(WIDTH, MODULUS)) begin : g_bad_cfg
      $error("mod_updown_counter: illegal WIDTH/MODULUS");
   end

   logic [WIDTH-1:0] next;
   logic             wrap;
   logic             clamp;

   mod_counter_next #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_next (
      .count    (count),
      .up       (up),
      .en       (en),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
      .next     (next),
      .wrap     (wrap),
      .clamp    (clamp),
      .tc       (tc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count    <= '0;
         carry    <= 1'b0;
         load_err <= 1'b0;
      end else begin
         count    <= next;
         carry    <= wrap;
         load_err <= clamp;
      end
   end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench: two builds (4b/mod10 and 3b/mod8) vs a model.
// Honours MOD_COUNTER_SATURATE_EN in the reference model.
module tb_mod_updown_counter;

   import mod_counter_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic       up = 1'b1;
   logic       clr = 1'b0;
   logic       load = 1'b0;
   logic [3:0] lv1 = '0;
   logic [2:0] lv2 = '0;

   logic [3:0] count1;
   logic       tc1, carry1, lerr1;
   logic [2:0] count2;
   logic       tc2, carry2, lerr2;

   int checks = 0;
   int errors = 0;

   int m1 = 0, c1 = 0, e1 = 0;
   int m2 = 0, c2 = 0, e2 = 0;

   always #5 clk = ~clk;

   mod_updown_counter #(.WIDTH(4), .MODULUS(10)) dut1 (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up       (up),
      .clr      (clr),
      .load     (load),
      .load_val (lv1),
      .count    (count1),
      .tc       (tc1),
      .carry    (carry1),
      .load_err (lerr1)
   );

   mod_updown_counter #(.WIDTH(3), .MODULUS(8)) dut2 (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up       (up),
      .clr      (clr),
      .load     (load),
      .load_val (lv2),
      .count    (count2),
      .tc       (tc2),
      .carry    (carry2),
      .load_err (lerr2)
   );

   task automatic chk(input string tag, input logic [16:0] obs,
                      input logic [16:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: modular arithmetic straight from the counting rules.
   function automatic void mstep(input int m, input int c, input int lv,
                                 output int nc, output int cy,
                                 output int er);
      nc = c;
      cy = 0;
      er = 0;
      if (clr) begin
         nc = 0;
      end else if (load) begin
         nc = (lv >= m) ? m - 1 : lv;
         er = (lv >= m) ? 1 : 0;
      end else if (en) begin
         cy = (up == DIR_UP) ? int'(c == m - 1) : int'(c == 0);
         nc = (up == DIR_UP) ? (c + 1) % m : (c + m - 1) % m;
`ifdef MOD_COUNTER_SATURATE_EN
         if (cy != 0) nc = c;
`endif
      end
   endfunction

   task automatic compare(input string tag);
      chk({tag, ".count1"}, 17'(count1), 17'(m1));
      chk({tag, ".carry1"}, 17'(carry1), 17'(c1));
      chk({tag, ".lerr1"},  17'(lerr1),  17'(e1));
      chk({tag, ".tc1"}, 17'(tc1),
          17'((up && m1 == 9) || (!up && m1 == 0)));
      chk({tag, ".count2"}, 17'(count2), 17'(m2));
      chk({tag, ".carry2"}, 17'(carry2), 17'(c2));
      chk({tag, ".lerr2"},  17'(lerr2),  17'(e2));
      chk({tag, ".tc2"}, 17'(tc2),
          17'((up && m2 == 7) || (!up && m2 == 0)));
   endtask

   task automatic tick(input string tag);
      int n1, n2;
      @(posedge clk);
      #1;
      mstep(10, m1, int'(lv1), n1, c1, e1);
      mstep(8,  m2, int'(lv2), n2, c2, e2);
      m1 = n1;
      m2 = n2;
      compare(tag);
   endtask

   task automatic set_in(input logic c, input logic l, input logic e,
                         input logic u, input int v1, input int v2);
      clr  = c;
      load = l;
      en   = e;
      up   = u;
      lv1  = 4'(v1);
      lv2  = 3'(v2);
   endtask

   initial begin
      #1;
      compare("reset");

      @(negedge clk);
      reset = 1'b1;
      set_in(0, 0, 1, 1, 0, 0);
      for (int i = 0; i < 12; i++) tick("up12");

      set_in(1, 0, 0, 1, 0, 0);
      tick("clr");
      set_in(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) tick("down");

      set_in(0, 1, 0, 1, 13, 5);
      tick("load13");
      set_in(0, 1, 0, 1, 5, 2);
      tick("load5");
      set_in(0, 0, 0, 1, 5, 2);
      tick("hold");

      set_in(0, 1, 0, 1, 7, 7);
      tick("load7");
      set_in(1, 1, 1, 1, 3, 3);
      tick("prio");

      set_in(0, 1, 0, 1, 6, 6);
      tick("load6");
      set_in(0, 1, 1, 0, 2, 2);
      #2;
      reset = 1'b0;
      #1;
      m1 = 0; c1 = 0; e1 = 0;
      m2 = 0; c2 = 0; e2 = 0;
      compare("async_rst");
      #1;
      reset = 1'b1;
      set_in(0, 0, 1, 1, 0, 0);
      tick("post_rst");

      set_in(0, 1, 0, 1, 9, 7);
      tick("load_top");
      set_in(0, 0, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) tick("end_up");
      set_in(0, 0, 1, 0, 0, 0);
      tick("dir_flip");

      for (int i = 0; i < 400; i++) begin
         set_in(1'($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)),
                int'($urandom_range(0, 15)),
                int'($urandom_range(0, 7)));
         tick("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
